// File: rtl/stack_mem_arbiter_if.sv
// Bus bundle between the core, the stack/memory arbiter and data memory.
// The arbiter connects through the slave modport; the core/memory side uses master.
interface stack_mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              LsReq;
    logic              LsWe;
    logic [ADDR_W-1:0] LsAddr;
    logic [DATA_W-1:0] LsWData;
    logic              LsDone;
    logic [DATA_W-1:0] LsRData;
    logic              StackReq;
    logic [1:0]        StackOp;
    logic [DATA_W-1:0] PushData;
    logic              StackDone;
    logic [DATA_W-1:0] PopData;
    logic              StackErr;
    logic              Stall;
    logic [ADDR_W-1:0] Sp;
    logic              Empty;
    logic              Full;
    logic              MemReq;
    logic              MemWe;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              MemAck;

    modport slave (
        input  LsReq, LsWe, LsAddr, LsWData, StackReq, StackOp, PushData, MemRData, MemAck,
        output LsDone, LsRData, StackDone, PopData, StackErr, Stall, Sp, Empty, Full,
               MemReq, MemWe, MemAddr, MemWData
    );

    modport master (
        output LsReq, LsWe, LsAddr, LsWData, StackReq, StackOp, PushData, MemRData, MemAck,
        input  LsDone, LsRData, StackDone, PopData, StackErr, Stall, Sp, Empty, Full,
               MemReq, MemWe, MemAddr, MemWData
    );
endinterface

// File: rtl/stack_mem_arbiter.sv
// Shares one data-memory port between the core load/store path and the stack
// engine. Owns the stack pointer and depth count, flags overflow/underflow.
//
// state   | meaning
// --------+------------------------------------------------
// IDLE    | no access in flight, arbitration happens here
// LS_WAIT | load/store access waiting for MemAck
// ST_WAIT | push/pop access waiting for MemAck
// DONE    | completion cycle, Done pulse high, back to IDLE
module stack_mem_arbiter #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] STACK_BASE  = 32'h0000_1000,
    parameter int                STACK_DEPTH = 256
) (
    input  logic               clk,
    input  logic               rst,
    stack_mem_arbiter_if.slave bus
);
    localparam int                CNT_W    = $clog2(STACK_DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(STACK_DEPTH);
    localparam logic [ADDR_W-1:0] WORD     = ADDR_W'(4);
    localparam logic [1:0]        OP_PUSH  = 2'b10;
    localparam logic [1:0]        OP_POP   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_LS_WAIT, S_ST_WAIT, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic              r_ls_done, w_ls_done_nxt;
    logic [DATA_W-1:0] r_ls_rdata, w_ls_rdata_nxt;
    logic              r_st_done, w_st_done_nxt;
    logic [DATA_W-1:0] r_pop_data, w_pop_data_nxt;
    logic              r_st_err, w_st_err_nxt;
    logic [ADDR_W-1:0] r_sp, w_sp_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_empty, r_full;
    // r_prio_ls = 1 means LS wins the next tie (it was not granted last).
    logic              r_prio_ls, w_prio_ls_nxt;
    logic              r_is_push, w_is_push_nxt;
    logic              w_grant_ls, w_grant_st;

    assign w_grant_ls = bus.LsReq & (~bus.StackReq | r_prio_ls);
    assign w_grant_st = bus.StackReq & ~w_grant_ls;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and next registered-output decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_ls_done_nxt   = 1'b0;
        w_ls_rdata_nxt  = r_ls_rdata;
        w_st_done_nxt   = 1'b0;
        w_pop_data_nxt  = r_pop_data;
        w_st_err_nxt    = r_st_err;
        w_sp_nxt        = r_sp;
        w_cnt_nxt       = r_cnt;
        w_prio_ls_nxt   = r_prio_ls;
        w_is_push_nxt   = r_is_push;
        case (r_state)
            S_IDLE: begin
                if (w_grant_ls) begin
                    w_prio_ls_nxt   = 1'b0;
                    w_mem_addr_nxt  = bus.LsAddr;
                    w_mem_we_nxt    = bus.LsWe;
                    w_mem_wdata_nxt = bus.LsWData;
                    w_mem_req_nxt   = 1'b1;
                    w_state_nxt     = S_LS_WAIT;
                end else if (w_grant_st) begin
                    w_prio_ls_nxt = 1'b1;
                    case (bus.StackOp)
                        OP_PUSH: begin
                            if (r_full) begin
                                w_st_err_nxt   = 1'b1;
                                w_pop_data_nxt = '0;
                                w_st_done_nxt  = 1'b1;
                                w_state_nxt    = S_DONE;
                            end else begin
                                w_mem_addr_nxt  = r_sp - WORD;
                                w_mem_we_nxt    = 1'b1;
                                w_mem_wdata_nxt = bus.PushData;
                                w_mem_req_nxt   = 1'b1;
                                w_is_push_nxt   = 1'b1;
                                w_state_nxt     = S_ST_WAIT;
                            end
                        end
                        OP_POP: begin
                            if (r_empty) begin
                                w_st_err_nxt   = 1'b1;
                                w_pop_data_nxt = '0;
                                w_st_done_nxt  = 1'b1;
                                w_state_nxt    = S_DONE;
                            end else begin
                                w_mem_addr_nxt = r_sp;
                                w_mem_we_nxt   = 1'b0;
                                w_mem_req_nxt  = 1'b1;
                                w_is_push_nxt  = 1'b0;
                                w_state_nxt    = S_ST_WAIT;
                            end
                        end
                        default: begin
                            w_st_err_nxt  = 1'b0;
                            w_st_done_nxt = 1'b1;
                            w_state_nxt   = S_DONE;
                        end
                    endcase
                end
            end
            S_LS_WAIT: begin
                if (bus.MemAck) begin
                    w_mem_req_nxt  = 1'b0;
                    w_ls_rdata_nxt = bus.MemRData;
                    w_ls_done_nxt  = 1'b1;
                    w_state_nxt    = S_DONE;
                end
            end
            S_ST_WAIT: begin
                if (bus.MemAck) begin
                    w_mem_req_nxt = 1'b0;
                    w_st_err_nxt  = 1'b0;
                    w_st_done_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                    if (r_is_push) begin
                        w_sp_nxt  = r_sp - WORD;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end else begin
                        w_pop_data_nxt = bus.MemRData;
                        w_sp_nxt       = r_sp + WORD;
                        w_cnt_nxt      = r_cnt - CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                w_st_err_nxt = 1'b0;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_ls_done   <= 1'b0;
            r_ls_rdata  <= '0;
            r_st_done   <= 1'b0;
            r_pop_data  <= '0;
            r_st_err    <= 1'b0;
            r_sp        <= STACK_BASE;
            r_cnt       <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_prio_ls   <= 1'b1;
            r_is_push   <= 1'b0;
        end else begin
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_ls_done   <= w_ls_done_nxt;
            r_ls_rdata  <= w_ls_rdata_nxt;
            r_st_done   <= w_st_done_nxt;
            r_pop_data  <= w_pop_data_nxt;
            r_st_err    <= w_st_err_nxt;
            r_sp        <= w_sp_nxt;
            r_cnt       <= w_cnt_nxt;
            r_empty     <= (w_cnt_nxt == '0);
            r_full      <= (w_cnt_nxt == CNT_FULL);
            r_prio_ls   <= w_prio_ls_nxt;
            r_is_push   <= w_is_push_nxt;
        end
    end

    assign bus.MemReq    = r_mem_req;
    assign bus.MemWe     = r_mem_we;
    assign bus.MemAddr   = r_mem_addr;
    assign bus.MemWData  = r_mem_wdata;
    assign bus.LsDone    = r_ls_done;
    assign bus.LsRData   = r_ls_rdata;
    assign bus.StackDone = r_st_done;
    assign bus.PopData   = r_pop_data;
    assign bus.StackErr  = r_st_err;
    assign bus.Sp        = r_sp;
    assign bus.Empty     = r_empty;
    assign bus.Full      = r_full;
    // Stall is the only combinational output: it must drop in the Done cycle.
    assign bus.Stall     = (bus.LsReq | bus.StackReq) & ~(r_ls_done | r_st_done);
endmodule

// File: tb/tb_stack_mem_arbiter.sv
// Self-checking bench for stack_mem_arbiter: fixed vectors, corner sequences and
// randomized traffic against a transaction-level stack/memory model.
module tb_stack_mem_arbiter;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    stack_mem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    stack_mem_arbiter #(
        .DATA_W(32), .ADDR_W(32), .STACK_BASE(BASE), .STACK_DEPTH(DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int          m_depth;
    logic [31:0] m_stk[$];
    bit          m_prio_ls;
    logic [31:0] model_mem[logic [31:0]];
    logic [31:0] dev_mem[logic [31:0]];

    typedef struct {
        bit          is_ls;
        bit          mem;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        bit          err;
        bit          chk_data;
        logic [31:0] rdata;
        logic [31:0] sp_after;
        bit          empty_after;
        bit          full_after;
        int          d;
    } grant_t;

    typedef struct {
        bit          ls_v;
        bit          ls_we;
        logic [31:0] ls_addr;
        logic [31:0] ls_wd;
        bit          st_v;
        logic [1:0]  op;
        logic [31:0] push;
        int          d;
        bit          chk_data;
        logic [31:0] exp_data;
        bit          exp_err;
        logic [31:0] exp_sp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_sp();
        return BASE - 32'(4 * m_depth);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] dev_rd(input logic [31:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic void model_reset();
        m_depth   = 0;
        m_stk.delete();
        m_prio_ls = 1'b1;
    endfunction

    function automatic grant_t model_grant(input bit is_ls, input bit ls_we, input logic [31:0] ls_addr,
                                           input logic [31:0] ls_wd, input logic [1:0] op,
                                           input logic [31:0] push_d, input int d);
        grant_t g;
        g = '{default: 0};
        g.is_ls = is_ls;
        g.d     = d;
        if (is_ls) begin
            m_prio_ls = 1'b0;
            g.mem   = 1'b1;
            g.addr  = ls_addr;
            g.we    = ls_we;
            g.wdata = ls_wd;
            if (ls_we) model_mem[ls_addr] = ls_wd;
            else begin
                g.rdata    = model_rd(ls_addr);
                g.chk_data = 1'b1;
            end
        end else begin
            m_prio_ls = 1'b1;
            if (op == 2'b10) begin
                if (m_depth == DEPTH) begin
                    g.err = 1'b1; g.chk_data = 1'b1; g.rdata = '0;
                end else begin
                    g.mem   = 1'b1;
                    g.we    = 1'b1;
                    g.addr  = m_sp() - 32'd4;
                    g.wdata = push_d;
                    m_stk.push_back(push_d);
                    model_mem[g.addr] = push_d;
                    m_depth++;
                end
            end else if (op == 2'b11) begin
                if (m_depth == 0) begin
                    g.err = 1'b1; g.chk_data = 1'b1; g.rdata = '0;
                end else begin
                    g.mem      = 1'b1;
                    g.we       = 1'b0;
                    g.addr     = m_sp();
                    g.rdata    = m_stk.pop_back();
                    g.chk_data = 1'b1;
                    m_depth--;
                end
            end
        end
        g.sp_after    = m_sp();
        g.empty_after = (m_depth == 0);
        g.full_after  = (m_depth == DEPTH);
        return g;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; bus.LsReq = 1'b0; bus.StackReq = 1'b0; bus.MemAck = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One transaction: LS and/or stack requests raised together, held until their
    // Done, memory acknowledging each access d cycles after MemReq rises.
    task automatic run_txn(input bit ls_v, input bit ls_we, input logic [31:0] ls_addr, input logic [31:0] ls_wd,
                           input bit st_v, input logic [1:0] op, input logic [31:0] push_d,
                           input int d_ls, input int d_st,
                           output logic [31:0] a_data, output bit a_err, output logic [31:0] a_sp,
                           output int a_ls_c, output int a_st_c);
        grant_t g[2];
        int     n, t, kr, done_ls, done_st;
        int     t_lo[2], ack_c[2], done_c[2];
        bit     e_lsd[64], e_std[64];
        bit     ls_first, take_ls, ack, exp_req;
        a_data = '0; a_err = 1'b0; a_sp = '0; a_ls_c = -1; a_st_c = -1;
        n = 0; t = 0; done_ls = -1; done_st = -1;
        for (int c = 0; c < 64; c++) begin e_lsd[c] = 1'b0; e_std[c] = 1'b0; end
        ls_first = ls_v && (!st_v || m_prio_ls);
        for (int k = 0; k < 2; k++) begin
            take_ls = (k == 0) ? ls_first : !ls_first;
            if (take_ls && ls_v) begin
                g[n] = model_grant(1'b1, ls_we, ls_addr, ls_wd, op, push_d, d_ls); n++;
            end else if (!take_ls && st_v) begin
                g[n] = model_grant(1'b0, ls_we, ls_addr, ls_wd, op, push_d, d_st); n++;
            end
        end
        for (int k = 0; k < 2; k++) begin t_lo[k] = -1; ack_c[k] = -1; done_c[k] = -1; end
        for (int k = 0; k < n; k++) begin
            if (g[k].mem) begin
                t_lo[k] = t + 1; ack_c[k] = t + 1 + g[k].d; done_c[k] = ack_c[k] + 1; t = ack_c[k] + 2;
            end else begin
                done_c[k] = t + 1; t = t + 2;
            end
            if (g[k].is_ls) begin done_ls = done_c[k]; e_lsd[done_c[k]] = 1'b1; end
            else            begin done_st = done_c[k]; e_std[done_c[k]] = 1'b1; end
        end

        @(posedge clk); #1;
        bus.LsReq = ls_v; bus.LsWe = ls_we; bus.LsAddr = ls_addr; bus.LsWData = ls_wd;
        bus.StackReq = st_v; bus.StackOp = op; bus.PushData = push_d; bus.MemAck = 1'b0;
        for (int c = 1; c <= t; c++) begin
            @(posedge clk); #1;
            bus.LsReq    = ls_v && (c <= done_ls);
            bus.StackReq = st_v && (c <= done_st);
            ack = 1'b0;
            for (int k = 0; k < n; k++) if (ack_c[k] == c) ack = 1'b1;
            bus.MemAck = ack;
            if (ack) begin
                bus.MemRData = dev_rd(bus.MemAddr);
                if (bus.MemWe) dev_mem[bus.MemAddr] = bus.MemWData;
            end else bus.MemRData = 32'hBAD0_0000 | 32'(c);
            #1;
            exp_req = 1'b0; kr = 0;
            for (int k = 0; k < n; k++)
                if (t_lo[k] >= 0 && c >= t_lo[k] && c <= ack_c[k]) begin exp_req = 1'b1; kr = k; end
            check("MemReq", bus.MemReq, exp_req);
            check("LsDone", bus.LsDone, e_lsd[c]);
            check("StackDone", bus.StackDone, e_std[c]);
            check("Stall", bus.Stall, (bus.LsReq | bus.StackReq) & ~(e_lsd[c] | e_std[c]));
            if (exp_req) begin
                check("MemAddr", bus.MemAddr, g[kr].addr);
                check("MemWe", bus.MemWe, g[kr].we);
                if (g[kr].we) check("MemWData", bus.MemWData, g[kr].wdata);
            end
            for (int k = 0; k < n; k++) if (done_c[k] == c) begin
                if (g[k].is_ls) begin
                    a_ls_c = c; a_data = bus.LsRData;
                    if (g[k].chk_data) check("LsRData", bus.LsRData, g[k].rdata);
                end else begin
                    a_st_c = c; a_data = bus.PopData; a_err = bus.StackErr;
                    check("StackErr", bus.StackErr, g[k].err);
                    if (g[k].chk_data) check("PopData", bus.PopData, g[k].rdata);
                end
                a_sp = bus.Sp;
                check("Sp", bus.Sp, g[k].sp_after);
                check("Empty", bus.Empty, g[k].empty_after);
                check("Full", bus.Full, g[k].full_after);
            end
        end
        bus.MemAck = 1'b0;
    endtask

    vec_t        vecs[12];
    logic [31:0] r_data, r_sp;
    bit          r_err;
    int          r_lc, r_sc;
    bit          got;

    initial begin
        bus.LsReq = 0; bus.LsWe = 0; bus.LsAddr = '0; bus.LsWData = '0;
        bus.StackReq = 0; bus.StackOp = 2'b00; bus.PushData = '0;
        bus.MemRData = '0; bus.MemAck = 0;
        model_reset();

        //            ls_v we addr          wdata          st op     push           d  chk data           err sp
        vecs[0]  = '{0, 0, 32'h0,        32'h0,         1, 2'b10, 32'hDEAD_BEEF, 0, 0, 32'h0,         0, 32'h0FFC};
        vecs[1]  = '{0, 0, 32'h0,        32'h0,         1, 2'b11, 32'h0,         3, 1, 32'hDEAD_BEEF, 0, 32'h1000};
        vecs[2]  = '{0, 0, 32'h0,        32'h0,         1, 2'b11, 32'h0,         0, 1, 32'h0,         1, 32'h1000};
        vecs[3]  = '{0, 0, 32'h0,        32'h0,         1, 2'b00, 32'h0,         0, 0, 32'h0,         0, 32'h1000};
        vecs[4]  = '{0, 0, 32'h0,        32'h0,         1, 2'b01, 32'h0,         0, 0, 32'h0,         0, 32'h1000};
        vecs[5]  = '{1, 1, 32'h2000,     32'h1234_5678, 0, 2'b00, 32'h0,         1, 0, 32'h0,         0, 32'h1000};
        vecs[6]  = '{1, 0, 32'h2000,     32'h0,         0, 2'b00, 32'h0,         2, 1, 32'h1234_5678, 0, 32'h1000};
        vecs[7]  = '{0, 0, 32'h0,        32'h0,         1, 2'b10, 32'h0000_0011, 1, 0, 32'h0,         0, 32'h0FFC};
        vecs[8]  = '{0, 0, 32'h0,        32'h0,         1, 2'b10, 32'h0000_0022, 0, 0, 32'h0,         0, 32'h0FF8};
        vecs[9]  = '{1, 0, 32'h2004,     32'h0,         0, 2'b00, 32'h0,         0, 1, 32'hA5A5_2004, 0, 32'h0FF8};
        vecs[10] = '{0, 0, 32'h0,        32'h0,         1, 2'b11, 32'h0,         1, 1, 32'h0000_0022, 0, 32'h0FFC};
        vecs[11] = '{0, 0, 32'h0,        32'h0,         1, 2'b11, 32'h0,         2, 1, 32'h0000_0011, 0, 32'h1000};

        do_reset();
        check("rst_MemReq", bus.MemReq, 1'b0);
        check("rst_MemWe", bus.MemWe, 1'b0);
        check("rst_MemAddr", bus.MemAddr, 32'h0);
        check("rst_MemWData", bus.MemWData, 32'h0);
        check("rst_LsDone", bus.LsDone, 1'b0);
        check("rst_LsRData", bus.LsRData, 32'h0);
        check("rst_StackDone", bus.StackDone, 1'b0);
        check("rst_PopData", bus.PopData, 32'h0);
        check("rst_StackErr", bus.StackErr, 1'b0);
        check("rst_Sp", bus.Sp, BASE);
        check("rst_Empty", bus.Empty, 1'b1);
        check("rst_Full", bus.Full, 1'b0);
        check("rst_Stall", bus.Stall, 1'b0);

        foreach (vecs[i]) begin
            run_txn(vecs[i].ls_v, vecs[i].ls_we, vecs[i].ls_addr, vecs[i].ls_wd, vecs[i].st_v, vecs[i].op,
                    vecs[i].push, vecs[i].d, vecs[i].d, r_data, r_err, r_sp, r_lc, r_sc);
            if (vecs[i].chk_data) check($sformatf("tbl%0d_data", i), r_data, vecs[i].exp_data);
            if (vecs[i].st_v) check($sformatf("tbl%0d_err", i), r_err, vecs[i].exp_err);
            check($sformatf("tbl%0d_sp", i), r_sp, vecs[i].exp_sp);
        end

        // Simultaneous requests after reset: LS first, and LS again on the next tie.
        do_reset();
        run_txn(1, 0, 32'h2010, 32'h0, 1, 2'b10, 32'h0000_CAFE, 1, 2, r_data, r_err, r_sp, r_lc, r_sc);
        check("tie1_ls_first", r_lc < r_sc, 1'b1);
        run_txn(1, 1, 32'h2014, 32'h0BAD_F00D, 1, 2'b11, 32'h0, 0, 1, r_data, r_err, r_sp, r_lc, r_sc);
        check("tie2_ls_first", r_lc < r_sc, 1'b1);
        check("tie2_pop", r_data, 32'h0000_CAFE);

        // Reset while a load is waiting for MemAck; the late ack must be ignored.
        do_reset();
        bus.LsReq = 1'b1; bus.LsWe = 1'b0; bus.LsAddr = 32'h2040;
        got = 1'b0;
        for (int w = 0; w < 10 && !got; w++) begin
            @(posedge clk); #1;
            if (bus.MemReq) got = 1'b1;
        end
        check("mr_req_rise", got, 1'b1);
        rst = 1'b1; bus.LsReq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_MemReq", bus.MemReq, 1'b0);
        check("mr_LsDone", bus.LsDone, 1'b0);
        check("mr_Sp", bus.Sp, BASE);
        check("mr_Empty", bus.Empty, 1'b1);
        bus.MemAck = 1'b1; bus.MemRData = 32'h5555_5555;
        @(posedge clk); #1;
        bus.MemAck = 1'b0;
        check("mr_late_LsDone", bus.LsDone, 1'b0);
        check("mr_late_MemReq", bus.MemReq, 1'b0);
        check("mr_late_LsRData", bus.LsRData, 32'h0);
        @(posedge clk); #1;
        check("mr_late_LsDone2", bus.LsDone, 1'b0);
        model_reset();
        run_txn(0, 0, 32'h0, 32'h0, 1, 2'b10, 32'h77, 1, 1, r_data, r_err, r_sp, r_lc, r_sc);
        check("mr_push_sp", r_sp, 32'h0FFC);

        // Fill to capacity, overflow, then pop the top.
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            run_txn(0, 0, 32'h0, 32'h0, 1, 2'b10, 32'(i * 3 + 7), 0, 0, r_data, r_err, r_sp, r_lc, r_sc);
        run_txn(0, 0, 32'h0, 32'h0, 1, 2'b10, 32'hFFFF_FFFF, 0, 0, r_data, r_err, r_sp, r_lc, r_sc);
        check("full_err", r_err, 1'b1);
        check("full_sp", r_sp, 32'h0000_0C00);
        check("full_flag", bus.Full, 1'b1);
        run_txn(0, 0, 32'h0, 32'h0, 1, 2'b11, 32'h0, 2, 2, r_data, r_err, r_sp, r_lc, r_sc);
        check("full_pop", r_data, 32'((DEPTH - 1) * 3 + 7));
        check("full_pop_sp", r_sp, 32'h0000_0C04);

        // Randomized mixed traffic against the model.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            int          sel, opsel;
            logic [1:0]  op;
            sel   = $urandom_range(0, 2);
            opsel = $urandom_range(0, 5);
            op    = (opsel < 3) ? 2'b10 : (opsel < 5) ? 2'b11 : 2'($urandom_range(0, 1));
            run_txn(sel != 1, 1'($urandom_range(0, 1)), 32'h2000 + 32'(4 * $urandom_range(0, 15)), $urandom,
                    sel != 0, op, $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                    r_data, r_err, r_sp, r_lc, r_sc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
